// File: rtl/data_req_pkg.sv
// rtl/data_req_pkg.sv - size/state encodings and helpers for data_req_unit
package data_req_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The reserved size code 3 behaves exactly like a word transfer.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'd3) ? SZ_W : sz;
  endfunction

  // Expects an already-normalised size.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/data_align.sv
// rtl/data_align.sv - byte strobe and lane-replicated write data generation
module data_align
  import data_req_pkg::*;
(
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata
);

  // Replicate the source across lanes so the slave picks the right lane by strobe.
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = i_data;
    case (i_size)
      SZ_B: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_data[7:0]}};
      end
      SZ_H: begin
        o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_data[15:0]}};
      end
      default: o_wstrb = 4'b1111;
    endcase
    if (!i_wr) begin
      o_wstrb = 4'b0000;
    end
  end

endmodule

// File: rtl/data_req_unit.sv
// rtl/data_req_unit.sv - single-outstanding data bus request unit (option: DATA_REQ_ALIGN_EXC_EN)
module data_req_unit
  import data_req_pkg::*;
#(
  parameter int ADDR_W = 32  // only 32 is supported
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic              in_wr,
  input  logic [1:0]        in_size,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_st_data,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rdata,
  output logic [1:0]        out_addr_lo,
  output logic              out_ale
);

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_capture;
  logic                w_misalign;
  logic [1:0]          w_size;
  logic [3:0]          w_wstrb;
  logic [31:0]         w_wdata;

  logic                r_wr;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;

  assign w_size = norm_size(in_size);

  data_align u_align (
    .i_wr      (in_wr),
    .i_size    (w_size),
    .i_addr_lo (in_addr[1:0]),
    .i_data    (in_st_data),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata)
  );

`ifdef DATA_REQ_ALIGN_EXC_EN
  logic r_ale;

  assign w_misalign = is_misaligned(w_size, in_addr[1:0]);
  assign out_ale    = r_ale;

  // Remember whether the accepted op was short-circuited as misaligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ale <= 1'b0;
    end else if (w_accept) begin
      r_ale <= w_misalign;
    end
  end
`else
  assign w_misalign = 1'b0;
  assign out_ale    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; data_data_ok is only honoured once the address phase has been accepted.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = w_misalign ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            w_capture = 1'b1;
            w_next    = S_DONE;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the op on accept so bus outputs stay stable; capture the response word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wstrb <= 4'b0000;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else if (w_accept) begin
      r_wr    <= in_wr;
      r_size  <= w_size;
      r_addr  <= in_addr;
      r_wstrb <= w_wstrb;
      r_wdata <= w_wdata;
      r_rdata <= 32'h0;
    end else if (w_capture) begin
      r_rdata <= r_wr ? 32'h0 : data_rdata;
    end
  end

  assign in_allowin  = (r_state == S_IDLE);
  assign data_req    = (r_state == S_REQ);
  assign out_valid   = (r_state == S_DONE);
  assign data_wr     = r_wr;
  assign data_size   = r_size;
  assign data_addr   = r_addr;
  assign data_wstrb  = r_wstrb;
  assign data_wdata  = r_wdata;
  assign out_rdata   = r_rdata;
  assign out_addr_lo = r_addr[1:0];

endmodule

// File: tb/tb_data_req_unit.sv
// tb/tb_data_req_unit.sv - self-checking bench for data_req_unit
module tb_data_req_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_allowin;
  logic        in_wr;
  logic [1:0]  in_size;
  logic [31:0] in_addr;
  logic [31:0] in_st_data;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_addr_lo;
  logic        out_ale;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_req_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_allowin   (in_allowin),
    .in_wr        (in_wr),
    .in_size      (in_size),
    .in_addr      (in_addr),
    .in_st_data   (in_st_data),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rdata    (out_rdata),
    .out_addr_lo  (out_addr_lo),
    .out_ale      (out_ale)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] d;
    logic [31:0] rd;
    int          aok;
    int          dok;
    int          rdy;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [1:0]  esz;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: strobes cover the naturally aligned lane group holding addr.
  function automatic logic [3:0] m_strb(input logic wr, input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] s;
    int nb;
    int base;
    s = 4'b0000;
    if (!wr) return s;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = ((a % 4) / nb) * nb;
    for (int i = 0; i < nb; i++) s[base + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    int nb;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
    return w;
  endfunction

  task automatic do_txn(input string nm, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] d, input logic [31:0] rd,
                        input int aok, input int dok, input int rdy,
                        input logic [3:0] e_strb, input logic [31:0] e_wdata, input logic [1:0] e_sz);
    logic [31:0] e_rd;
    e_rd = wr ? 32'h0 : rd;
    chk({nm, ".allowin_idle"}, in_allowin, 1);
    in_valid = 1'b1; in_wr = wr; in_size = sz; in_addr = addr; in_st_data = d;
    tick();
    in_valid = 1'b0; in_addr = ~addr; in_st_data = ~d;
    chk({nm, ".req"}, data_req, 1);
    chk({nm, ".allowin_busy"}, in_allowin, 0);
    chk({nm, ".wr"}, data_wr, wr);
    chk({nm, ".size"}, data_size, e_sz);
    chk({nm, ".addr"}, data_addr, addr);
    chk({nm, ".wstrb"}, data_wstrb, e_strb);
    if (wr) chk({nm, ".wdata"}, data_wdata, e_wdata);
    for (int i = 0; i < aok; i++) begin
      data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
      tick();
      data_data_ok = 1'b0;
      chk({nm, ".req_hold"}, data_req, 1);
      chk({nm, ".addr_hold"}, data_addr, addr);
      chk({nm, ".wstrb_hold"}, data_wstrb, e_strb);
      chk({nm, ".no_early_valid"}, out_valid, 0);
    end
    data_addr_ok = 1'b1;
    if (dok == 0) begin
      data_data_ok = 1'b1; data_rdata = rd;
    end
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'hBAD0BAD0;
    if (dok > 0) begin
      chk({nm, ".wait_noreq"}, data_req, 0);
      chk({nm, ".wait_novalid"}, out_valid, 0);
      for (int i = 1; i < dok; i++) begin
        tick();
        chk({nm, ".wait_novalid"}, out_valid, 0);
      end
      data_data_ok = 1'b1; data_rdata = rd;
      tick();
      data_data_ok = 1'b0; data_rdata = 32'hBAD0BAD0;
    end
    chk({nm, ".out_valid"}, out_valid, 1);
    chk({nm, ".out_rdata"}, out_rdata, e_rd);
    chk({nm, ".out_addr_lo"}, out_addr_lo, addr[1:0]);
    chk({nm, ".out_ale"}, out_ale, 0);
    chk({nm, ".done_noreq"}, data_req, 0);
    for (int i = 0; i < rdy; i++) begin
      data_data_ok = 1'b1;
      tick();
      data_data_ok = 1'b0;
      chk({nm, ".valid_hold"}, out_valid, 1);
      chk({nm, ".allowin_hold"}, in_allowin, 0);
      chk({nm, ".rdata_hold"}, out_rdata, e_rd);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, ".valid_drop"}, out_valid, 0);
    chk({nm, ".allowin_back"}, in_allowin, 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".allowin"}, in_allowin, 1);
    chk({nm, ".req"}, data_req, 0);
    chk({nm, ".wr"}, data_wr, 0);
    chk({nm, ".size"}, data_size, 0);
    chk({nm, ".addr"}, data_addr, 0);
    chk({nm, ".wstrb"}, data_wstrb, 0);
    chk({nm, ".wdata"}, data_wdata, 0);
    chk({nm, ".out_valid"}, out_valid, 0);
    chk({nm, ".out_rdata"}, out_rdata, 0);
    chk({nm, ".out_addr_lo"}, out_addr_lo, 0);
    chk({nm, ".out_ale"}, out_ale, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        r_wr;
    logic [1:0]  r_sz;
    logic [1:0]  r_esz;
    logic [31:0] r_addr;
    logic [31:0] r_d;
    logic [31:0] r_rd;

    //            wr    sz    addr          d             rd            aok dok rdy strb     wdata         esz
    tbl[0] = '{1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5, 32'hFFFF_0000, 0, 1, 0, 4'b1000, 32'hA5A5_A5A5, 2'd0};
    tbl[1] = '{1'b0, 2'd2, 32'h0000_2000, 32'h0000_0000, 32'h1234_5678, 3, 1, 0, 4'b0000, 32'h0,         2'd2};
    tbl[2] = '{1'b0, 2'd1, 32'h0000_3002, 32'h0000_0000, 32'hCAFE_F00D, 0, 0, 5, 4'b0000, 32'h0,         2'd1};
    tbl[3] = '{1'b1, 2'd0, 32'h0000_1000, 32'h1234_56C3, 32'h0,         1, 2, 1, 4'b0001, 32'hC3C3_C3C3, 2'd0};
    tbl[4] = '{1'b1, 2'd1, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,         0, 1, 0, 4'b1100, 32'hBEEF_BEEF, 2'd1};
    tbl[5] = '{1'b1, 2'd1, 32'h0000_2000, 32'h0000_CAFE, 32'h0,         2, 0, 0, 4'b0011, 32'hCAFE_CAFE, 2'd1};
    tbl[6] = '{1'b1, 2'd2, 32'h0000_3000, 32'h89AB_CDEF, 32'h0,         0, 3, 0, 4'b1111, 32'h89AB_CDEF, 2'd2};
    tbl[7] = '{1'b0, 2'd0, 32'h0000_5001, 32'h0000_0000, 32'hAABB_CCDD, 1, 1, 2, 4'b0000, 32'h0,         2'd0};
    tbl[8] = '{1'b1, 2'd3, 32'h0000_6000, 32'h1122_3344, 32'h0,         0, 1, 0, 4'b1111, 32'h1122_3344, 2'd2};

    reset = 1'b1; in_valid = 1'b0; in_wr = 1'b0; in_size = 2'd0; in_addr = 32'h0;
    in_st_data = 32'h0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      do_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].d, tbl[i].rd,
             tbl[i].aok, tbl[i].dok, tbl[i].rdy, tbl[i].strb, tbl[i].wdata, tbl[i].esz);
    end

    // Reset while waiting for the response abandons the op.
    in_valid = 1'b1; in_wr = 1'b1; in_size = 2'd2; in_addr = 32'h0000_7004; in_st_data = 32'hFEED_FACE;
    tick();
    in_valid = 1'b0;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    chk("rst_wait.pre_wr", data_wr, 1);
    reset = 1'b1;
    #1;
    chk_all_zero("rst_wait");
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
      tick();
      data_data_ok = 1'b0;
      chk("rst_wait.no_valid", out_valid, 0);
      chk("rst_wait.allowin", in_allowin, 1);
    end

`ifdef DATA_REQ_ALIGN_EXC_EN
    in_valid = 1'b1; in_wr = 1'b0; in_size = 2'd2; in_addr = 32'h0000_4001; in_st_data = 32'h0;
    tick();
    in_valid = 1'b0;
    chk("ale_w.noreq", data_req, 0);
    chk("ale_w.valid", out_valid, 1);
    chk("ale_w.ale", out_ale, 1);
    chk("ale_w.addr_lo", out_addr_lo, 1);
    chk("ale_w.rdata", out_rdata, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ale_w.idle", in_allowin, 1);
    in_valid = 1'b1; in_wr = 1'b1; in_size = 2'd1; in_addr = 32'h0000_3001;
    tick();
    in_valid = 1'b0;
    chk("ale_h.noreq", data_req, 0);
    chk("ale_h.ale", out_ale, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`else
    do_txn("mis_word", 1'b0, 2'd2, 32'h0000_4001, 32'h0, 32'h0BAD_F00D, 0, 1, 0,
           4'b0000, 32'h0, 2'd2);
    do_txn("mis_half", 1'b1, 2'd1, 32'h0000_3001, 32'h0000_9876, 32'h0, 1, 1, 0,
           4'b0011, 32'h9876_9876, 2'd1);
`endif

    for (int n = 0; n < 40; n++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_sz   = 2'($urandom_range(0, 3));
      r_addr = $urandom;
      r_d    = $urandom;
      r_rd   = $urandom;
      r_esz  = (r_sz == 2'd3) ? 2'd2 : r_sz;
`ifdef DATA_REQ_ALIGN_EXC_EN
      if (r_esz == 2'd1) r_addr[0] = 1'b0;
      if (r_esz == 2'd2) r_addr[1:0] = 2'b00;
`endif
      do_txn($sformatf("rnd%0d", n), r_wr, r_sz, r_addr, r_d, r_rd,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             m_strb(r_wr, r_esz, r_addr), m_wdata(r_esz, r_d), r_esz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_req_unit.md
DATA_REQ_UNIT -- requirements
Module: data_req_unit

Interface
REQ-001 Parameter: ADDR_W, 32, data-bus address width; only 32 SHALL be supported.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  EX stage presents a memory op.
REQ-005 in_allowin  output  1  unit can accept an op this cycle.
REQ-006 in_wr  input  1  1 = store, 0 = load.
REQ-007 in_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and SHALL be treated as word.
REQ-008 in_addr  input  32  byte address.
REQ-009 in_st_data  input  32  store source register value.
REQ-010 data_req  output  1  bus request.
REQ-011 data_wr  output  1  bus request is a write.
REQ-012 data_size  output  2  bus transfer size.
REQ-013 data_addr  output  32  bus address.
REQ-014 data_wstrb  output  4  byte strobes.
REQ-015 data_wdata  output  32  lane-replicated write data.
REQ-016 data_addr_ok  input  1  request accepted.
REQ-017 data_data_ok  input  1  response complete.
REQ-018 data_rdata  input  32  read data, valid with data_data_ok.
REQ-019 out_valid  output  1  completed op presented to the MEM stage.
REQ-020 out_ready  input  1  MEM stage accepts the completed op.
REQ-021 out_rdata  output  32  raw read word (0 for stores).
REQ-022 out_addr_lo  output  2  in_addr[1:0] of the op, used for load extraction.
REQ-023 out_ale  output  1  alignment exception flag.

Function
REQ-024 The FSM SHALL have states IDLE, REQ, WAIT, DONE; in_allowin = (state == IDLE).
REQ-025 In IDLE, in_valid SHALL latch in_wr, in_size, in_addr and the aligned data and strobes, then move to REQ.
REQ-026 In REQ, data_req SHALL be 1 and all data_* outputs SHALL hold stable until data_addr_ok.
REQ-027 In REQ: data_addr_ok alone -> WAIT; data_addr_ok with data_data_ok in the same cycle -> DONE.
REQ-028 In WAIT, data_data_ok -> DONE, capturing data_rdata into out_rdata for loads and 0 for stores.
REQ-029 In DONE, out_valid SHALL be 1; out_ready -> IDLE.
REQ-030 Minimum latency: accept at cycle N, data_req at N+1, out_valid at N+3 when data_addr_ok is at N+1 and data_data_ok at N+2.
REQ-031 At most one transaction SHALL be outstanding; data_data_ok in IDLE, REQ-without-addr_ok or DONE SHALL be ignored.
REQ-032 Byte strobes: data_wstrb = 0001<<addr[1:0] for byte, 0011<<{addr[1],0} for half, 1111 for word; data_wstrb SHALL be 0000 for loads.
REQ-033 Write data: data_wdata = {4{d[7:0]}} for byte, {2{d[15:0]}} for half, d for word.
REQ-034 data_addr SHALL equal the latched in_addr unmodified; data_size SHALL equal the latched size.

Reset
REQ-035 On reset, state SHALL be IDLE and every output SHALL be 0 except in_allowin, which SHALL be 1.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction with no out_valid.

Configuration
REQ-037 With DATA_REQ_ALIGN_EXC_EN defined, a misaligned op (half with addr[0]=1, or word with addr[1:0]!=0) SHALL skip REQ and WAIT, go from IDLE directly to DONE, and set out_ale=1, with no data_req.
REQ-038 Without DATA_REQ_ALIGN_EXC_EN, out_ale SHALL be tied to 0 and misaligned ops SHALL be issued as-is.

Structure
REQ-039 Package data_req_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W) and the FSM state encodings.
REQ-040 Combinational strobe and wdata generation SHALL live in sub-module data_align.

Verification
REQ-041 Byte store, addr 0x1003, d=0x000000A5, addr_ok at +1, data_ok at +2 -> wstrb=1000, wdata=0xA5A5A5A5, out_valid at N+3, out_rdata=0.
REQ-042 Word load, addr 0x2000, addr_ok held low 3 cycles -> data_req and data_addr stable for 4 cycles; data_rdata=0x12345678 -> out_rdata=0x12345678.
REQ-043 Half load, addr 0x3002, addr_ok and data_ok in the same cycle -> direct REQ to DONE, out_addr_lo=2.
REQ-044 out_ready held low 5 cycles in DONE -> out_valid stays 1 and in_allowin stays 0; a stray data_data_ok is ignored.
REQ-045 Reset pulsed while in WAIT -> IDLE, all outputs 0, in_allowin=1, no out_valid.
REQ-046 With DATA_REQ_ALIGN_EXC_EN: word load at 0x4001 -> no data_req, out_valid and out_ale=1 at N+1.
